// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths, reset vector and fetch entry type for the fetch stage
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO with flush, registered head and occupancy count
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DEPTH[CW-1:0]);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Pop of an empty FIFO is ignored; a push into a full FIFO only lands when a pop frees the slot.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and count next-state; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !flush_i && full_o && !pop_i));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem requests, tag queue and output buffer
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_VECTOR,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   inflight, buf_count;
  logic [CW:0]     occupancy;
  logic [XLEN-1:0] tag_pc;
  logic            tag_full, tag_empty, buf_full, buf_empty;
  logic            req_fire, rsp_drop, buf_push, buf_pop;
  fetch_entry_t    head, push_entry;

  // inflight counts every outstanding request, stale or not, so it bounds tag queue usage.
  assign occupancy      = {1'b0, inflight} + {1'b0, buf_count};
  assign imem_req_valid = rst_n && !redirect_valid && (occupancy < FIFO_DEPTH[CW:0]);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response is discarded while stale requests remain, or when a redirect lands the same cycle.
  assign rsp_drop   = redirect_valid || (drop_cnt_q != '0);
  assign buf_push   = imem_rsp_valid && !rsp_drop;
  assign buf_pop    = out_valid && out_ready;
  assign push_entry = '{instr: imem_rsp_data, pc: tag_pc};

  assign out_valid = rst_n && !buf_empty;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

  // PC and drop counter next-state; a redirect marks every outstanding request as stale.
  always_comb begin
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
      drop_cnt_d = inflight - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(4);
      if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  // PC and drop counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // PC of each accepted request, popped by its (possibly dropped) in-order response.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_q (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (req_fire),
    .push_data_i (pc_q),
    .pop_i       (imem_rsp_valid),
    .flush_i     (1'b0),
    .head_o      (tag_pc),
    .count_o     (inflight),
    .full_o      (tag_full),
    .empty_o     (tag_empty)
  );

  // Instruction buffer presented to the decoder; flushed on redirect.
  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_buf_q (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (buf_push),
    .push_data_i (push_entry),
    .pop_i       (buf_pop),
    .flush_i     (redirect_valid),
    .head_o      (head),
    .count_o     (buf_count),
    .full_o      (buf_full),
    .empty_o     (buf_empty)
  );

  rsp_has_tag_a: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> !tag_empty);
  req_has_room_a: assert property (@(posedge clk) disable iff (!rst_n)
    req_fire |-> !tag_full);
  buf_has_room_a: assert property (@(posedge clk) disable iff (!rst_n)
    (buf_push && buf_full) |-> buf_pop);

endmodule
